// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Data-memory responder for the MEM-stage bus of a 5-stage CPU.
//             Word-organised RAM with byte/half/word access, load sign/zero
//             extension, byte-lane store merging, zero-fill after reset,
//             sticky misalign/range error capture, load/store counters and
//             a debug read port.
//  Ports    : clk, rst (async active-low)
//             mem_w, mem_r, addr, wdata, dm_type  -> request port
//             rdata (combinational load data), ready
//             err_misalign, err_range, err_addr, err_clr
//             load_cnt, store_cnt
//             dbg_addr -> dbg_data (combinational raw word)
//  Revision : 1.0  initial release
// ============================================================================
module dm_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_w,
    input  logic              mem_r,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        dm_type,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err_misalign,
    output logic              err_range,
    output logic [31:0]       err_addr,
    input  logic              err_clr,
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [31:0]       r_mem [DEPTH_WORDS];
    logic              r_err_mis;
    logic              r_err_rng;
    logic [31:0]       r_err_addr;
    logic [31:0]       r_load_cnt;
    logic [31:0]       r_store_cnt;

    logic              w_run;
    logic              w_is_half;
    logic              w_is_byte;
    logic              w_is_word;
    logic              w_unsigned;
    logic              w_mis;
    logic              w_rng;
    logic              w_valid;
    logic              w_store;
    logic              w_load;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_raw;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_rdata;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_data;
    logic [31:0]       w_merged;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_run      = (r_state == c_ST_RUN);
    assign w_is_half  = (dm_type == 3'b001) || (dm_type == 3'b010);
    assign w_is_byte  = (dm_type == 3'b011) || (dm_type == 3'b100);
    assign w_is_word  = !w_is_half && !w_is_byte;   // unknown codes act as word
    assign w_unsigned = (dm_type == 3'b010) || (dm_type == 3'b100);

    assign w_mis   = (w_is_word && (addr[1:0] != 2'b00)) || (w_is_half && addr[0]);
    assign w_rng   = |addr[31:ADDR_W+2];
    assign w_valid = w_run && !w_mis && !w_rng;
    assign w_idx   = addr[ADDR_W+1:2];
    assign w_raw   = r_mem[w_idx];

    // Store takes priority when both request strobes are high.
    assign w_store = w_valid && mem_w;
    assign w_load  = w_valid && mem_r && !mem_w;
    assign w_err   = w_run && (mem_r || mem_w) && (w_mis || w_rng);

    // ------------------------------------------------------------------
    // Load path: reads the pre-write RAM contents, so a same-cycle store
    // to the same word only becomes visible on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        w_half  = addr[1] ? w_raw[31:16] : w_raw[15:0];
        w_byte  = w_raw[7:0];
        case (addr[1:0])
            2'd0:    w_byte = w_raw[7:0];
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
        if (w_valid) begin
            if (w_is_half)
                w_rdata = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            else if (w_is_byte)
                w_rdata = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            else
                w_rdata = w_raw;
        end
    end

    // ------------------------------------------------------------------
    // Store path: replicate the right-aligned data into every lane and let
    // the byte enables pick which lanes overwrite the stored word.
    // ------------------------------------------------------------------
    always_comb begin
        w_be        = 4'hF;
        w_lane_data = wdata;
        if (w_is_half) begin
            w_be        = addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{wdata[15:0]}};
        end else if (w_is_byte) begin
            w_be        = 4'b0001 << addr[1:0];
            w_lane_data = {4{wdata[7:0]}};
        end
        w_merged = w_raw;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i])
                w_merged[8*i +: 8] = w_lane_data[8*i +: 8];
        end
    end

    // RAM array has no reset; the INIT state zero-fills it instead.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT)
            r_mem[r_init_ptr] <= '0;
        else if (w_store)
            r_mem[w_idx] <= w_merged;
    end

    // ------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_INIT;
            r_init_ptr <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
            if (r_init_ptr == c_LAST_IDX)
                r_state <= c_ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture; a new error in a clear cycle wins over the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_mis  <= 1'b0;
            r_err_rng  <= 1'b0;
            r_err_addr <= '0;
        end else if (err_clr) begin
            r_err_mis  <= w_err && w_mis;
            r_err_rng  <= w_err && w_rng;
            r_err_addr <= w_err ? addr : 32'h0;
        end else if (w_err) begin
            r_err_mis <= r_err_mis | w_mis;
            r_err_rng <= r_err_rng | w_rng;
            if (!r_err_mis && !r_err_rng)
                r_err_addr <= addr;
        end
    end

    // ------------------------------------------------------------------
    // Access counters (free-running, wrap)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_load)
                r_load_cnt <= r_load_cnt + 32'd1;
            if (w_store)
                r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

    assign rdata        = w_rdata;
    assign ready        = w_run;
    assign err_misalign = r_err_mis;
    assign err_range    = r_err_rng;
    assign err_addr     = r_err_addr;
    assign load_cnt     = r_load_cnt;
    assign store_cnt    = r_store_cnt;
    assign dbg_data     = w_run ? r_mem[dbg_addr] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_responder
//  Purpose  : Self-checking bench for dm_responder. Expected load data is
//             queued when a request is driven and compared on the following
//             falling edge; state outputs are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int ADDR_W      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_w = 1'b0;
    logic              mem_r = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic [2:0]        dm_type = '0;
    logic [31:0]       rdata;
    logic              ready;
    logic              err_misalign;
    logic              err_range;
    logic [31:0]       err_addr;
    logic              err_clr = 1'b0;
    logic [31:0]       load_cnt;
    logic [31:0]       store_cnt;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    bit          sb_pop = 1'b0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
        .wdata(wdata), .dm_type(dm_type), .rdata(rdata), .ready(ready),
        .err_misalign(err_misalign), .err_range(err_range), .err_addr(err_addr),
        .err_clr(err_clr), .load_cnt(load_cnt), .store_cnt(store_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: load data is combinational, compare mid-cycle.
    always @(negedge clk) begin
        if (sb_pop) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string       t = tag_q.pop_front();
                chk(t, rdata, e);
            end
        end
    end

    // Drive one request cycle just after a rising edge.
    task automatic req(input logic w, input logic r, input logic clr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t,
                       input bit pop, input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        mem_w = w; mem_r = r; err_clr = clr; addr = a; wdata = wd; dm_type = t;
        if (pop) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        sb_pop = pop;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mem_w = 0; mem_r = 0; err_clr = 0; sb_pop = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
        req(1, 0, 0, a, wd, t, 0, 0, "");
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] exp, input string tag);
        req(0, 1, 0, a, 0, t, 1, exp, tag);
    endtask

    task automatic dbg_chk(input logic [ADDR_W-1:0] idx, input logic [31:0] exp, input string tag);
        dbg_addr = idx; #1;
        chk(tag, dbg_data, exp);
    endtask

    // Count rising edges until ready; returns the number of edges seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk); #1;
            mem_w = 0; mem_r = 0;
            n++;
        end
    endtask

    initial begin
        int n;
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_errs", {30'b0, err_misalign, err_range}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_cnts", load_cnt | store_cnt, 32'd0);

        rst = 1'b1;
        wait_ready(n);
        chk("init_len", n, 32'd256);
        @(negedge clk);
        dbg_chk(8'd0, 32'h0, "dbg_zero_0");
        dbg_chk(8'd128, 32'h0, "dbg_zero_128");
        dbg_chk(8'd255, 32'h0, "dbg_zero_255");

        // ---------------- load extension ----------------
        store(32'h10, 32'h80F17F01, 3'b000);
        load(32'h10, 3'b011, 32'h00000001, "lb_10");
        load(32'h11, 3'b011, 32'h0000007F, "lb_11");
        load(32'h13, 3'b011, 32'hFFFFFF80, "lb_13");
        load(32'h13, 3'b100, 32'h00000080, "lbu_13");
        load(32'h12, 3'b001, 32'hFFFF80F1, "lh_12");
        load(32'h12, 3'b010, 32'h000080F1, "lhu_12");
        load(32'h10, 3'b000, 32'h80F17F01, "lw_10");

        // ---------------- byte-lane merge ----------------
        store(32'h20, 32'h11223344, 3'b000);
        store(32'h22, 32'h0000BEEF, 3'b001);
        idle();
        @(negedge clk);
        dbg_chk(8'd8, 32'hBEEF3344, "merge_half");
        store(32'h21, 32'h000000AA, 3'b011);
        idle();
        @(negedge clk);
        dbg_chk(8'd8, 32'hBEEFAA44, "merge_byte");
        chk("store_cnt_4", store_cnt, 32'd4);
        chk("load_cnt_7", load_cnt, 32'd7);

        // ---------------- error capture ----------------
        store(32'h13, 32'hFFFFFFFF, 3'b000);
        idle();
        @(negedge clk);
        dbg_chk(8'd4, 32'h80F17F01, "mis_no_write");
        chk("mis_flag", {31'b0, err_misalign}, 32'd1);
        chk("mis_addr", err_addr, 32'h13);
        chk("mis_no_cnt", store_cnt, 32'd4);
        load(32'h400, 3'b000, 32'h0, "rng_rdata");
        idle();
        @(negedge clk);
        chk("rng_flag", {31'b0, err_range}, 32'd1);
        chk("rng_addr_kept", err_addr, 32'h13);
        chk("rng_no_cnt", load_cnt, 32'd7);
        req(0, 1, 1, 32'h02, 0, 3'b000, 1, 32'h0, "clr_mis_rdata");
        idle();
        @(negedge clk);
        chk("clr_new_flags", {30'b0, err_misalign, err_range}, 32'd2);
        chk("clr_new_addr", err_addr, 32'h02);
        req(0, 0, 1, 32'h0, 0, 3'b000, 0, 0, "");
        idle();
        @(negedge clk);
        chk("clr_only", {30'b0, err_misalign, err_range} | err_addr, 32'd0);

        // ---------------- same-cycle store/load ----------------
        req(1, 1, 0, 32'h30, 32'hCAFEF00D, 3'b000, 1, 32'h0, "rw_old");
        load(32'h30, 3'b000, 32'hCAFEF00D, "rw_new");
        idle();
        @(negedge clk);
        chk("rw_store_cnt", store_cnt, 32'd5);
        chk("rw_load_cnt", load_cnt, 32'd8);

        // ---------------- counter wrap ----------------
        force dut.r_load_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_load_cnt;
        #1;
        chk("wrap_pre", load_cnt, 32'hFFFF_FFFF);
        load(32'h10, 3'b000, 32'h80F17F01, "wrap_ld");
        idle();
        @(negedge clk);
        chk("wrap_zero", load_cnt, 32'd0);

        // ---------------- init restart ----------------
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart_ready", {31'b0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_w = 1; addr = 32'h40; wdata = 32'hDEADBEEF; dm_type = 3'b000;
        #1;
        chk("init_dbg_zero", dbg_data, 32'h0);
        wait_ready(n);
        chk("restart_len", n, 32'd256);
        @(negedge clk);
        chk("init_store_cnt", store_cnt, 32'd0);
        dbg_chk(8'd16, 32'h0, "init_store_dropped");
        dbg_chk(8'd4, 32'h0, "refill_zero");
        mem_r = 1; mem_w = 0; addr = 32'h20; dm_type = 3'b000;
        #1;
        chk("refill_rdata", rdata, 32'h0);
        mem_r = 0;

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
